// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the flash programming port,
// instruction fetch and load/store, and routes synchronous read data back to its requester.
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flash_en,
  input  logic [WIDTH-1:0] flash_addr,
  input  logic [WIDTH-1:0] flash_data,
  output logic             flash_pending,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  logic             fb_valid_r;
  logic [WIDTH-1:0] fb_addr_r;
  logic [WIDTH-1:0] fb_data_r;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  logic             starved_s;
  logic             grant_flash_s;
  logic             grant_if_s;
  logic             grant_d_s;
  owner_e           rd_owner_r;
  owner_e           rd_owner_nxt_s;

  // Flash holding register: a strobe in the draining cycle refills it, so no overflow path exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_valid_r <= 1'b0;
      fb_addr_r  <= {WIDTH{1'b0}};
      fb_data_r  <= {WIDTH{1'b0}};
    end else if (flash_en) begin
      fb_valid_r <= 1'b1;
      fb_addr_r  <= flash_addr;
      fb_data_r  <= flash_data;
    end else if (fb_valid_r) begin
      fb_valid_r <= 1'b0;
    end
  end

  assign flash_pending = fb_valid_r;
  assign starved_s     = (starve_cnt_r == CNT_W'(STARVE_LIMIT));

  // Fixed-priority grant: flash, starved fetch, data, fetch.
  always_comb begin
    grant_flash_s = 1'b0;
    grant_if_s    = 1'b0;
    grant_d_s     = 1'b0;
    if (fb_valid_r) begin
      grant_flash_s = 1'b1;
    end else if (if_req && starved_s) begin
      grant_if_s = 1'b1;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else if (if_req) begin
      grant_if_s = 1'b1;
    end else begin
      grant_flash_s = 1'b0;
      grant_if_s    = 1'b0;
      grant_d_s     = 1'b0;
    end
  end

  assign if_gnt = grant_if_s;
  assign d_gnt  = grant_d_s;

  // Memory port steered from the winner; an idle port is driven to all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {WIDTH{1'b0}};
    mem_wdata = {WIDTH{1'b0}};
    if (grant_flash_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fb_addr_r;
      mem_wdata = fb_data_r;
    end else if (grant_if_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = {WIDTH{1'b0}};
    end else if (grant_d_s) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {WIDTH{1'b0}};
      mem_wdata = {WIDTH{1'b0}};
    end
  end

  // Starvation count: flash grants deny fetch too, so they keep the count rather than clear it.
  always_comb begin
    starve_cnt_nxt_s = {CNT_W{1'b0}};
    if (if_req && !grant_if_s) begin
      if (starved_s) begin
        starve_cnt_nxt_s = starve_cnt_r;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
      end
    end else begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Read-return owner state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_r <= OWN_NONE;
    end else begin
      rd_owner_r <= rd_owner_nxt_s;
    end
  end

  // Next owner: only reads produce a return; stores and flash writes leave it NONE.
  always_comb begin
    rd_owner_nxt_s = OWN_NONE;
    if (grant_if_s) begin
      rd_owner_nxt_s = OWN_IF;
    end else if (grant_d_s && !d_we) begin
      rd_owner_nxt_s = OWN_D;
    end else begin
      rd_owner_nxt_s = OWN_NONE;
    end
  end

  // Return qualifiers decoded from the owner state.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (rd_owner_r)
      OWN_IF: begin
        if_rvalid = 1'b1;
        d_rvalid  = 1'b0;
      end
      OWN_D: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b1;
      end
      default: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
      end
    endcase
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between three requesters: the flash programming port, the core's instruction-fetch port and the core's load/store port. It sits in `top` between the core and the memory. Flash writes are registered, then committed with absolute priority. Data accesses normally beat fetches, and a starvation counter guarantees fetch progress. Read data from the memory's 1-cycle synchronous read is routed back to the requester that was granted.

## Interface
- `WIDTH`, 32: address and data width.
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch is promoted above data. Legal range is ≥1.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high. Driven from power-on reset, not from the core reset, so flashing works while the core is held in reset.
- `flash_en`  in  1  one-cycle write strobe for the flash port.
- `flash_addr`  in  WIDTH  flash write byte address.
- `flash_data`  in  WIDTH  flash write data.
- `flash_pending`  out  1  flash holding register is occupied.
- `if_req`  in  1  fetch request, held until `if_gnt`.
- `if_addr`  in  WIDTH  fetch address.
- `if_gnt`  out  1  fetch granted this cycle.
- `if_rvalid`  out  1  `if_rdata` is valid.
- `if_rdata`  out  WIDTH  fetched instruction.
- `d_req`  in  1  data request, held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  WIDTH  data address.
- `d_wdata`  in  WIDTH  store data.
- `d_gnt`  out  1  data request granted this cycle.
- `d_rvalid`  out  1  `d_rdata` is valid (loads only).
- `d_rdata`  out  WIDTH  load data.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  WIDTH  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_rdata`  in  WIDTH  memory read data, valid 1 cycle after a read with `mem_en=1`, `mem_we=0`.

## Operation
- **Flash holding register** (`fb_valid`, `fb_addr`, `fb_data`):
  - `flash_en` loads the register at the rising edge and sets `fb_valid`.
  - A valid buffer is always issued the next cycle.
  - `flash_en` in a cycle when the buffer drains refills it. Back-to-back strobes therefore never lose data and need no overflow path.
  - `flash_pending` = `fb_valid`.
- **Grant priority** (combinational, one grant per cycle):
  1. Flash buffer, if `fb_valid`.
  2. Fetch, if `if_req` and `starve_cnt == STARVE_LIMIT`.
  3. Data, if `d_req`.
  4. Fetch, if `if_req`.
  5. Otherwise idle.
- **Memory port drive:**
  - `mem_*` are driven combinationally from the winner. A flash grant forces `mem_we=1`. A fetch grant forces `mem_we=0`.
  - When idle: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- **Starvation counter** (`starve_cnt`, width `$clog2(STARVE_LIMIT+1)`):
  - Increments by 1 on each cycle with `if_req && !if_gnt`, saturating at `STARVE_LIMIT`.
  - Clears to 0 on `if_gnt` or `!if_req`.
  - A flash grant during starvation does not clear the counter. Fetch wins the next non-flash cycle.
- **Return routing** (`rd_owner` register: NONE / IF / D):
  - Set at the rising edge to the requester granted a read this cycle, otherwise NONE.
  - `if_rvalid` = (`rd_owner == IF`). `d_rvalid` = (`rd_owner == D`).
  - `if_rdata` and `d_rdata` both pass `mem_rdata` through. They are qualified only by their rvalid.
  - Stores and flash writes produce no rvalid.

## Timing
- **Reset values:** `fb_valid=0`, `starve_cnt=0`, `rd_owner=NONE`. Consequently `flash_pending=0`, `if_gnt=0`, `d_gnt=0`, `if_rvalid=0`, `d_rvalid=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. Rdata outputs follow `mem_rdata`.
- **Reset mid-operation:**
  - Asserting `rst` clears the buffer immediately. A pending flash word is lost.
  - An in-flight read loses its rvalid.
  - `flash_en` sampled while `rst=1` is ignored.
- **Latencies:**
  - Grant: 0 cycles from request when it wins.
  - Read data: rvalid exactly 1 cycle after grant.
  - Flash: commit to memory 1 cycle after the `flash_en` edge.
- **Pipelining:** a read can be granted every cycle. Back-to-back grants produce back-to-back rvalids in grant order.
- **Requester rule:** requesters sample `gnt` at the rising edge and may change request or address only after it.
- **Simultaneous events:**
  - Flash, data and fetch all requesting: flash wins. Data wins next, unless fetch is starved.
  - Fetch and data requesting in the same cycle with `starve_cnt == STARVE_LIMIT`: fetch wins.

## Test plan
- **Flash loading:** with core requests idle, strobe `flash_en` for 0x24←0x1, then 0x28←0x1 on consecutive cycles.
  - Required: `mem_we=1` writes at addresses 0x24 and 0x28, one and two cycles after the first strobe.
  - Required: `flash_pending` high for exactly 2 cycles.
  - Required: no rvalid.
- **Flash preempts core:** hold `if_req` (addr 0x0) and `d_req` (load 0x24) continuously, and strobe `flash_en` once.
  - Required: in the commit cycle `if_gnt=0` and `d_gnt=0`.
  - Required: in the following cycle the data load is granted, then `d_rvalid=1` with `d_rdata=0x1`.
- **Starvation guard:** with `STARVE_LIMIT=4`, hold `d_req` continuously (new loads each grant) and `if_req` at 0x8.
  - Required: the fetch is granted on the 5th cycle, then `if_rvalid` with the memory word at 0x8.
  - Required: `starve_cnt` returns to 0 after the fetch grant.
- **Pipelined reads:** grant alternating fetch 0x0 and load 0x28 on four consecutive cycles.
  - Required: rvalids alternate `if_rvalid` / `d_rvalid` one cycle delayed, each with the correct data.
- **Stores:** a `d_we=1` store of 0xDEADBEEF to 0x30, followed by a load from 0x30.
  - Required: no rvalid for the store.
  - Required: the load returns 0xDEADBEEF.
- **Reset mid-operation:** assert `rst` asynchronously with a flash word pending and a read in flight.
  - Required: `flash_pending`, `mem_en` and both rvalids go low immediately, with no memory write after `rst` deasserts.
